multi_channel_timer: RTL
========================

MULTI_CHANNEL_TIMER -- requirements
Module: multi_channel_timer

Interface
REQ-001 Parameter NUM_CH, default 4, number of independent timer channels.
REQ-002 Parameter CNT_WIDTH, default 16, per-channel counter width.
REQ-003 Parameter PRESCALER_WIDTH, default 3, selector width.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 prescaler_selector  input  PRESCALER_WIDTH  shared divisor: 0->1, 1->8, 2->64, 3->256, 4->1024, others->1.
REQ-007 ch_enable  input  NUM_CH  per-channel run enable.
REQ-008 ch_mode  input  2*NUM_CH  per channel: 0 overflow-periodic, 1 compare-periodic, 2 one-shot, 3 PWM.
REQ-009 ch_limit  input  CNT_WIDTH*NUM_CH  per-channel period value.
REQ-010 ch_duty  input  CNT_WIDTH*NUM_CH  per-channel PWM high-time.
REQ-011 irq_clear  input  NUM_CH  per-channel pending-clear strobe.
REQ-012 interrupt_request  output  NUM_CH  sticky per-channel pending flag.
REQ-013 irq_any  output  1  OR of interrupt_request.
REQ-014 TLTF  output  NUM_CH  per-channel timer-limit toggle flag.
REQ-015 pwm_out  output  NUM_CH  per-channel PWM waveform.
REQ-016 ch_busy  output  NUM_CH  one-shot channel counting.

Function
REQ-017 Prescaler: 10-bit free-running counter, increments every cycle while any ch_enable bit set and selector maps to divisor >1; otherwise held.
REQ-018 tick: 1 every cycle for divisor 1; else 1 when prescaler low log2(divisor) bits all ones.
REQ-019 Terminal value: mode 0 -> 2^CNT_WIDTH-1; modes 1-3 -> ch_limit-1; ch_limit==0 in modes 1-3 -> 2^CNT_WIDTH-1.
REQ-020 Channel counter, when enabled and tick: if counter >= terminal -> 0 (terminal event), else +1.
REQ-021 Terminal event: interrupt_request bit set and TLTF bit toggled on the same clock edge as counter wrap (1 cycle after the tick cycle observing terminal).
REQ-022 ch_enable low: channel counter cleared to 0, ch_busy 0; interrupt_request and TLTF retained.
REQ-023 irq_clear bit high clears the pending bit next edge; simultaneous terminal event and clear -> bit stays set.
REQ-024 One-shot (mode 2): ch_busy set on rising edge of ch_enable (or entry into mode 2 while enabled); counts to terminal, raises event once, counter stays 0, ch_busy 0, no further events until ch_enable deasserts and reasserts.
REQ-025 PWM (mode 3): pwm_out = enabled AND (counter < ch_duty); ch_duty 0 -> constant 0; ch_duty >= ch_limit -> constant 1; periodic events as mode 1.
REQ-026 pwm_out is 0 for any channel not in mode 3 or disabled.
REQ-027 Mode/limit changes take effect immediately; counter above new terminal wraps at next tick (>= rule).
REQ-028 Channels are fully independent except for the shared prescaler tick.

Reset
REQ-029 rst: prescaler, all counters, interrupt_request, irq_any, TLTF, pwm_out, ch_busy = 0; applies mid-count, overrides irq_clear and tick.

Configuration
REQ-030 Macro TIMER_PWM_EN defined: PWM mode and pwm_out as in REQ-025/026.
REQ-031 TIMER_PWM_EN undefined: pwm_out tied 0, ch_duty ignored, mode 3 behaves exactly as mode 1; no PWM comparators synthesised.

Verification
REQ-032 selector 0, ch0 mode 1, limit 5, enable -> interrupt_request[0] rises every 5 cycles after first, TLTF[0] toggles each period.
REQ-033 selector 1, ch1 mode 0, CNT_WIDTH 16 -> first event after 8*65536 cycles; irq_any follows.
REQ-034 ch2 mode 2, limit 10 -> single event, ch_busy[2] high 10 ticks then 0; re-toggle enable -> second event.
REQ-035 ch3 mode 3, limit 10, duty 3 -> pwm_out[3] high 3 of every 10 cycles; duty 0 -> low; duty 12 -> high; TIMER_PWM_EN undefined -> always 0.
REQ-036 irq_clear asserted same cycle as terminal event -> pending remains 1; rst asserted mid-count -> all outputs 0 next edge, counting restarts from 0.

Source files
------------

// File: rtl/multi_channel_timer_if.sv
// -----------------------------------------------------------------------------
// multi_channel_timer_if
// Groups the configuration inputs and status outputs of multi_channel_timer.
//   master : drives configuration (prescaler_selector, ch_enable, ch_mode,
//            ch_limit, ch_duty, irq_clear) and observes status
//   slave  : the timer; receives configuration, drives interrupt_request,
//            irq_any, TLTF, pwm_out, ch_busy
// Channel fields are packed LSB-first: channel i occupies
//   ch_mode[2*i +: 2], ch_limit/ch_duty[CNT_WIDTH*i +: CNT_WIDTH].
// -----------------------------------------------------------------------------
interface multi_channel_timer_if #(
    parameter int NUM_CH          = 4,
    parameter int CNT_WIDTH       = 16,
    parameter int PRESCALER_WIDTH = 3
);
    logic [PRESCALER_WIDTH-1:0]  prescaler_selector;
    logic [NUM_CH-1:0]           ch_enable;
    logic [2*NUM_CH-1:0]         ch_mode;
    logic [CNT_WIDTH*NUM_CH-1:0] ch_limit;
    logic [CNT_WIDTH*NUM_CH-1:0] ch_duty;
    logic [NUM_CH-1:0]           irq_clear;

    logic [NUM_CH-1:0]           interrupt_request;
    logic                        irq_any;
    logic [NUM_CH-1:0]           TLTF;
    logic [NUM_CH-1:0]           pwm_out;
    logic [NUM_CH-1:0]           ch_busy;

    modport master (
        output prescaler_selector, ch_enable, ch_mode, ch_limit, ch_duty, irq_clear,
        input  interrupt_request, irq_any, TLTF, pwm_out, ch_busy
    );

    modport slave (
        input  prescaler_selector, ch_enable, ch_mode, ch_limit, ch_duty, irq_clear,
        output interrupt_request, irq_any, TLTF, pwm_out, ch_busy
    );
endinterface

// File: rtl/multi_channel_timer.sv
// -----------------------------------------------------------------------------
// multi_channel_timer
// NUM_CH independent up-counting timer channels sharing one prescaler tick.
// Per-channel modes: 0 overflow-periodic, 1 compare-periodic, 2 one-shot,
// 3 PWM. A terminal event sets the sticky interrupt_request bit and toggles
// the TLTF bit on the same edge that the counter wraps to 0.
//
// Ports
//   clk  : single clock, all state on the rising edge
//   rst  : synchronous active-high reset
//   bus  : multi_channel_timer_if.slave (configuration in, status out)
//
// Build option
//   TIMER_PWM_EN : when defined, mode 3 drives pwm_out from a duty compare.
//                  When undefined, pwm_out is tied 0, ch_duty is ignored and
//                  mode 3 behaves exactly as mode 1.
//
// One-shot FSM (one per channel)
//   state   | meaning
//   OS_IDLE | not armed (disabled, not in mode 2, or arming this edge)
//   OS_BUSY | one-shot counting toward terminal, ch_busy = 1
//   OS_DONE | event delivered; parked until enable drops or mode leaves 2
// -----------------------------------------------------------------------------
module multi_channel_timer #(
    parameter int NUM_CH          = 4,
    parameter int CNT_WIDTH       = 16,
    parameter int PRESCALER_WIDTH = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    multi_channel_timer_if.slave  bus
);

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        OS_IDLE = 2'd0,
        OS_BUSY = 2'd1,
        OS_DONE = 2'd2
    } os_state_t;

    // ------------------------------------------------------------------
    // Shared prescaler
    // ------------------------------------------------------------------
    logic [9:0]        r_presc;
    logic [9:0]        w_presc_mask;
    logic              w_presc_run;
    logic              w_tick;

    logic [NUM_CH-1:0] w_irq_vec;
    logic [NUM_CH-1:0] w_tltf_vec;
    logic [NUM_CH-1:0] w_pwm_vec;
    logic [NUM_CH-1:0] w_busy_vec;

    // The mask holds log2(divisor) low ones; divisor 1 gives an empty mask,
    // which makes the tick compare true every cycle.
    always_comb begin
        w_presc_mask = 10'd0;
        case (bus.prescaler_selector)
            PRESCALER_WIDTH'(1): w_presc_mask = 10'h007;
            PRESCALER_WIDTH'(2): w_presc_mask = 10'h03F;
            PRESCALER_WIDTH'(3): w_presc_mask = 10'h0FF;
            PRESCALER_WIDTH'(4): w_presc_mask = 10'h3FF;
            default:             w_presc_mask = 10'd0;
        endcase
    end

    assign w_presc_run = (|bus.ch_enable) && (w_presc_mask != 10'd0);
    assign w_tick      = ((r_presc & w_presc_mask) == w_presc_mask);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_presc <= 10'd0;
        end else if (w_presc_run) begin
            r_presc <= r_presc + 10'd1;
        end
    end

    // ------------------------------------------------------------------
    // Channels
    // ------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            logic                 w_en;
            logic [1:0]           w_mode;
            logic [CNT_WIDTH-1:0] w_limit;
            logic [CNT_WIDTH-1:0] w_term;
            logic [CNT_WIDTH-1:0] w_cnt_nxt;
            logic                 w_counting;
            logic                 w_event;
            logic [CNT_WIDTH-1:0] r_cnt;
            logic                 r_irq;
            logic                 r_tltf;
            os_state_t            r_os_state;
            os_state_t            w_os_next;

            assign w_en    = bus.ch_enable[gi];
            assign w_mode  = bus.ch_mode[2*gi +: 2];
            assign w_limit = bus.ch_limit[CNT_WIDTH*gi +: CNT_WIDTH];

            // Mode 0 always runs the full range; a zero limit would
            // underflow, so it is treated as full range as well.
            assign w_term = ((w_mode == 2'd0) || (w_limit == '0)) ?
                            CNT_MAX : (w_limit - CNT_WIDTH'(1));

            // A one-shot channel only advances while its FSM is armed.
            assign w_counting = w_en && w_tick &&
                                ((w_mode != 2'd2) || (r_os_state == OS_BUSY));

            // >= rather than == so a counter left above a freshly lowered
            // terminal wraps at the next tick instead of running to overflow.
            assign w_event = w_counting && (r_cnt >= w_term);

            always_comb begin
                w_cnt_nxt = r_cnt;
                if (!w_en) begin
                    w_cnt_nxt = '0;
                end else if (w_event) begin
                    w_cnt_nxt = '0;
                end else if (w_counting) begin
                    w_cnt_nxt = r_cnt + CNT_WIDTH'(1);
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_cnt  <= '0;
                    r_irq  <= 1'b0;
                    r_tltf <= 1'b0;
                end else begin
                    r_cnt <= w_cnt_nxt;
                    // A new event wins over a coincident clear.
                    if (w_event) begin
                        r_irq <= 1'b1;
                    end else if (bus.irq_clear[gi]) begin
                        r_irq <= 1'b0;
                    end
                    if (w_event) begin
                        r_tltf <= ~r_tltf;
                    end
                end
            end

            // One-shot FSM: state register
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_os_state <= OS_IDLE;
                end else begin
                    r_os_state <= w_os_next;
                end
            end

            // One-shot FSM: next state. Reaching IDLE while enabled in mode 2
            // can only happen on a fresh enable or a fresh entry into mode 2,
            // so IDLE arms unconditionally under those conditions.
            always_comb begin
                w_os_next = r_os_state;
                if (!w_en || (w_mode != 2'd2)) begin
                    w_os_next = OS_IDLE;
                end else begin
                    case (r_os_state)
                        OS_IDLE: w_os_next = OS_BUSY;
                        OS_BUSY: if (w_event) w_os_next = OS_DONE;
                        OS_DONE: w_os_next = OS_DONE;
                        default: w_os_next = OS_IDLE;
                    endcase
                end
            end

            assign w_irq_vec[gi]  = r_irq;
            assign w_tltf_vec[gi] = r_tltf;
            assign w_busy_vec[gi] = (r_os_state == OS_BUSY);

`ifdef TIMER_PWM_EN
            logic [CNT_WIDTH-1:0] w_duty;
            logic                 r_pwm;

            assign w_duty = bus.ch_duty[CNT_WIDTH*gi +: CNT_WIDTH];

            // Registered against the next counter value so the waveform
            // stays aligned with the counter it is derived from.
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_pwm <= 1'b0;
                end else begin
                    r_pwm <= w_en && (w_mode == 2'd3) && (w_cnt_nxt < w_duty);
                end
            end

            assign w_pwm_vec[gi] = r_pwm;
`else
            assign w_pwm_vec[gi] = 1'b0;
`endif
        end
    endgenerate

`ifndef TIMER_PWM_EN
    // Duty is meaningless without the PWM comparators.
    logic w_unused_duty;
    assign w_unused_duty = ^bus.ch_duty;
`endif

    assign bus.interrupt_request = w_irq_vec;
    assign bus.irq_any           = |w_irq_vec;
    assign bus.TLTF              = w_tltf_vec;
    assign bus.pwm_out           = w_pwm_vec;
    assign bus.ch_busy           = w_busy_vec;

endmodule
